seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the multi-digit 7-segment display. It holds a double-buffered BCD display value and steps through the digits at a programmable refresh rate. For each digit it drives the BCD code and blank request into the per-digit BCD-to-7-segment decoder, then drives the matching active-low anode. Anode switching is aligned to the decoder's one-cycle registered latency and uses a one-cycle dead gap to prevent ghosting.

---
 rtl/seg7_scan_ctrl.sv | 116 +++++++++++
 tb/tb_seg7_scan_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed 7-segment scan controller with a double-buffered BCD value
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                          clk_100MHz,
    input  logic                          reset_n,
    input  logic                          en,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       value_bcd,
    input  logic                          blank_lz,
    output logic [3:0]                    digit_bcd,
    output logic                          digit_blank,
    output logic [NUM_DIGITS-1:0]         anode_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done,
    output logic                          load_ack
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int W  = 4 * NUM_DIGITS;

    typedef enum logic {GAP, SHOW} state_t;

    state_t              state_q, state_d;
    logic                gap_q, gap_d;
    logic [W-1:0]        shadow_q, shadow_d, active_q, active_d;
    logic                pending_q, pending_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [3:0]          digit_bcd_q, digit_bcd_d;
    logic                digit_blank_q, digit_blank_d;
    logic [NUM_DIGITS-1:0] anode_n_q, anode_n_d;
    logic                frame_done_q, frame_done_d;
    logic                load_ack_q, load_ack_d;
    logic                tick, wrap, commit, zero_run, zero_hit;

    assign tick   = en && presc_q == PW'(REFRESH_DIV - 1);
    assign wrap   = tick && idx_q == '0;
    assign commit = wrap && pending_q;

    assign digit_bcd   = digit_bcd_q;
    assign digit_blank = digit_blank_q;
    assign anode_n     = anode_n_q;
    assign digit_idx   = idx_q;
    assign frame_done  = frame_done_q;
    assign load_ack    = load_ack_q;

    // Prescaler, digit stepping, load handshake and decoder drive; the new digit uses the just-committed value
    always_comb begin
        presc_d      = tick ? '0 : presc_q + PW'(en);
        idx_d        = tick ? (idx_q == '0 ? IW'(NUM_DIGITS - 1) : idx_q - IW'(1)) : idx_q;
        shadow_d     = load ? value_bcd : shadow_q;
        active_d     = commit ? shadow_q : active_q;
        pending_d    = load || (pending_q && !commit);
        frame_done_d = wrap;
        load_ack_d   = commit;
        zero_run     = 1'b1;
        zero_hit     = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && active_d[4*i +: 4] == 4'd0;
            zero_hit = IW'(i) == idx_d ? zero_run : zero_hit;
        end
        digit_bcd_d   = tick ? active_d[{idx_d, 2'b00} +: 4] : digit_bcd_q;
        digit_blank_d = tick ? (blank_lz && idx_d != '0 && zero_hit) : digit_blank_q;
    end

    // Next state: any tick or disable restarts a two-cycle dead gap before the anode turns on
    always_comb begin
        state_d = (!en || tick) ? GAP : (state_q == GAP && !gap_q) ? GAP : SHOW;
        gap_d   = en && !tick && state_q == GAP && !gap_q;
    end

    // Anode drive registered from the next state so it switches together with the FSM
    always_comb begin
        anode_n_d = state_d == SHOW ? ~(NUM_DIGITS'(1) << idx_d) : '1;
    end

    // FSM state register
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= GAP;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q      <= '0;
            active_q      <= '0;
            pending_q     <= 1'b0;
            presc_q       <= '0;
            idx_q         <= '0;
            digit_bcd_q   <= 4'd0;
            digit_blank_q <= 1'b1;
            anode_n_q     <= '1;
            frame_done_q  <= 1'b0;
            load_ack_q    <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            digit_bcd_q   <= digit_bcd_d;
            digit_blank_q <= digit_blank_d;
            anode_n_q     <= anode_n_d;
            frame_done_q  <= frame_done_d;
            load_ack_q    <= load_ack_d;
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed checks of scan order, gap timing, blanking and load handshake
module tb_seg7_scan_ctrl;
    logic        clk = 1'b0;
    logic        reset_n, en, load, blank_lz;
    logic [15:0] value_bcd;
    logic [3:0]  digit_bcd;
    logic        digit_blank;
    logic [3:0]  anode_n;
    logic [1:0]  digit_idx;
    logic        frame_done, load_ack;
    int          total = 0;
    int          bad = 0;

    seg7_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk_100MHz(clk),
        .reset_n(reset_n),
        .en(en),
        .load(load),
        .value_bcd(value_bcd),
        .blank_lz(blank_lz),
        .digit_bcd(digit_bcd),
        .digit_blank(digit_blank),
        .anode_n(anode_n),
        .digit_idx(digit_idx),
        .frame_done(frame_done),
        .load_ack(load_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_chk();
        chk("rst_anode", anode_n, 4'hF);
        chk("rst_bcd", digit_bcd, 0);
        chk("rst_blank", digit_blank, 1);
        chk("rst_idx", digit_idx, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_ack", load_ack, 0);
    endtask

    // Entered one cycle after the tick that selected digit k; leaves one cycle after the next tick.
    task automatic slot(input int k, input logic [3:0] b, input logic bl, input logic ack,
                        input logic lt, input logic [15:0] lv);
        logic [3:0] on;
        on = ~(4'b0001 << k);
        chk("idx", digit_idx, k);
        chk("bcd", digit_bcd, b);
        chk("blank", digit_blank, bl);
        chk("anode_gap0", anode_n, 4'hF);
        chk("frame_done", frame_done, k == 3);
        chk("load_ack", load_ack, ack);
        step();
        load = 1'b0;
        chk("anode_gap1", anode_n, 4'hF);
        chk("fd_one_cycle", frame_done, 0);
        chk("ack_one_cycle", load_ack, 0);
        step();
        chk("anode_show0", anode_n, on);
        step();
        chk("anode_show1", anode_n, on);
        if (lt) begin
            value_bcd = lv;
            load = 1'b1;
        end
        step();
        load = 1'b0;
    endtask

    task automatic frame(input logic [15:0] v, input logic [3:0] bl, input logic ack,
                         input logic lt, input logic [15:0] lv);
        for (int k = 3; k >= 0; k--)
            slot(k, v[4*k +: 4], bl[k], ack && k == 3, lt && k == 0, lv);
    endtask

    task automatic release_rst();
        reset_n = 1'b1;
        en = 1'b1;
        repeat (4) step();
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b0; load = 1'b0; blank_lz = 1'b0; value_bcd = 16'h0;
        repeat (3) step();
        rst_chk();
        release_rst();
        value_bcd = 16'h1234; load = 1'b1;
        frame(16'h0000, 4'b0000, 0, 0, 0);
        value_bcd = 16'h0050; load = 1'b1; blank_lz = 1'b1;
        frame(16'h1234, 4'b0000, 1, 0, 0);
        value_bcd = 16'h0000; load = 1'b1;
        frame(16'h0050, 4'b1100, 1, 0, 0);
        value_bcd = 16'h1111; load = 1'b1;
        slot(3, 4'h0, 1, 1, 0, 0);
        value_bcd = 16'h2222; load = 1'b1;
        slot(2, 4'h0, 1, 0, 0, 0);
        slot(1, 4'h0, 1, 0, 0, 0);
        slot(0, 4'h0, 0, 0, 0, 0);
        frame(16'h2222, 4'b0000, 1, 0, 0);
        frame(16'h2222, 4'b0000, 0, 1, 16'h9876);
        frame(16'h2222, 4'b0000, 0, 0, 0);
        value_bcd = 16'h3333; load = 1'b1;
        frame(16'h9876, 4'b0000, 1, 1, 16'h4444);
        frame(16'h3333, 4'b0000, 1, 0, 0);
        value_bcd = 16'h00A0; load = 1'b1;
        frame(16'h4444, 4'b0000, 1, 0, 0);
        frame(16'h00A0, 4'b1100, 1, 0, 0);
        chk("en_fd", frame_done, 1);
        chk("en_idx", digit_idx, 3);
        step();
        chk("en_gap", anode_n, 4'hF);
        en = 1'b0;
        repeat (3) begin
            step();
            chk("en_off_anode", anode_n, 4'hF);
            chk("en_off_idx", digit_idx, 3);
        end
        en = 1'b1;
        step();
        chk("reen_gap", anode_n, 4'hF);
        chk("reen_gap_idx", digit_idx, 3);
        step();
        chk("reen_show", anode_n, 4'b0111);
        chk("reen_show_idx", digit_idx, 3);
        en = 1'b0;
        step();
        chk("drop_anode", anode_n, 4'hF);
        chk("drop_idx", digit_idx, 3);
        en = 1'b1;
        step();
        chk("resume_idx", digit_idx, 2);
        chk("resume_anode", anode_n, 4'hF);
        chk("resume_bcd", digit_bcd, 0);
        chk("resume_blank", digit_blank, 1);
        step();
        chk("resume_gap", anode_n, 4'hF);
        step();
        chk("resume_show", anode_n, 4'b1011);
        value_bcd = 16'h5555; load = 1'b1;
        step();
        load = 1'b0;
        chk("pre_rst_show", anode_n, 4'b1011);
        reset_n = 1'b0;
        #2;
        rst_chk();
        step();
        release_rst();
        frame(16'h0000, 4'b1110, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
